// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage pipeline: IF-stage FSM states, IF/ID field
// widths and the reset/bubble constants.
package pipeline_pkg;

  localparam int unsigned InstrWidth = 32;
  localparam int unsigned AddrWidth  = 32;

  localparam logic [AddrWidth-1:0]  DefaultResetPc = 32'h0000_0000;
  localparam logic [InstrWidth-1:0] DefaultNopWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHold,
    StDrain
  } if_state_e;

endpackage

// File: rtl/if_stage_if.sv
// Single-outstanding request/valid instruction-memory port.
interface if_stage_if;
  import pipeline_pkg::*;

  logic                  req;
  logic [AddrWidth-1:0]  addr;
  logic [InstrWidth-1:0] rdata;
  logic                  valid;

  modport master (output req, output addr, input rdata, input valid);
  modport slave  (input req, input addr, output rdata, output valid);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. A bubble takes priority over a load; with neither
// the contents hold.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter logic [InstrWidth-1:0] NOP_WORD = DefaultNopWord
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  bubble,
  input  logic [InstrWidth-1:0] instr_d,
  input  logic [AddrWidth-1:0]  next_addr_d,
  input  logic                  valid_d,
  output logic [InstrWidth-1:0] instr,
  output logic [AddrWidth-1:0]  next_addr,
  output logic                  valid
);

  logic [InstrWidth-1:0] instr_q;
  logic [AddrWidth-1:0]  next_addr_q;
  logic                  valid_q;

  // IF/ID state: reset and bubble both load the NOP with valid cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q     <= NOP_WORD;
      next_addr_q <= '0;
      valid_q     <= 1'b0;
    end else if (bubble) begin
      instr_q     <= NOP_WORD;
      next_addr_q <= '0;
      valid_q     <= 1'b0;
    end else if (load) begin
      instr_q     <= instr_d;
      next_addr_q <= next_addr_d;
      valid_q     <= valid_d;
    end
  end

  assign instr     = instr_q;
  assign next_addr = next_addr_q;
  assign valid     = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, the instruction-memory request FSM,
// a one-word hold buffer for responses that land during a stall, and the
// IF/ID register feeding the ID stage.
module if_stage
  import pipeline_pkg::*;
#(
  parameter logic [AddrWidth-1:0]  RESET_PC = DefaultResetPc,
  parameter logic [InstrWidth-1:0] NOP_WORD = DefaultNopWord
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCWrite,
  input  logic                  freeze,
  input  logic                  PCSrc,
  input  logic                  flush,
  input  logic [AddrWidth-1:0]  Branch_Address,
  if_stage_if.master            imem,
  output logic [InstrWidth-1:0] Instruction,
  output logic [AddrWidth-1:0]  Next_Address,
  output logic                  if_valid
);

  if_state_e             state_q, state_d;
  logic [AddrWidth-1:0]  pc_q, pc_d;
  logic [AddrWidth-1:0]  fetch_addr_q, fetch_addr_d;
  logic [InstrWidth-1:0] hold_q, hold_d;

  logic                  stall, redirect;
  logic [AddrWidth-1:0]  target, pc_plus4;
  logic                  ifid_load, ifid_bubble;
  logic [InstrWidth-1:0] ifid_instr;

  assign stall    = freeze | ~PCWrite;
  assign redirect = PCSrc | flush;
  // A flush without a taken branch re-fetches from the current PC.
  assign target   = PCSrc ? Branch_Address : pc_q;
  assign pc_plus4 = pc_q + 32'd4;

  // Next-state, PC/fetch-address update and IF/ID load/bubble decode.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    hold_d       = hold_q;
    ifid_load    = 1'b0;
    ifid_bubble  = 1'b0;
    ifid_instr   = imem.rdata;
    unique case (state_q)
      StIdle: begin
        if (redirect) begin
          pc_d        = target;
          ifid_bubble = 1'b1;
        end
        fetch_addr_d = pc_d;
        state_d      = StReq;
      end
      StReq: begin
        if (imem.valid) begin
          if (redirect) begin
            pc_d         = target;
            fetch_addr_d = target;
            ifid_bubble  = 1'b1;
          end else if (stall) begin
            hold_d  = imem.rdata;
            state_d = StHold;
          end else begin
            ifid_load    = 1'b1;
            pc_d         = pc_plus4;
            fetch_addr_d = pc_plus4;
          end
        end else if (redirect) begin
          // The old request must still complete; fetch_addr stays put.
          pc_d        = target;
          ifid_bubble = 1'b1;
          state_d     = StDrain;
        end else if (!stall) begin
          ifid_bubble = 1'b1;
        end
      end
      StHold: begin
        if (redirect) begin
          pc_d         = target;
          fetch_addr_d = target;
          ifid_bubble  = 1'b1;
          state_d      = StReq;
        end else if (!stall) begin
          ifid_load    = 1'b1;
          ifid_instr   = hold_q;
          pc_d         = pc_plus4;
          fetch_addr_d = pc_plus4;
          state_d      = StReq;
        end
      end
      StDrain: begin
        if (redirect) begin
          pc_d        = target;
          ifid_bubble = 1'b1;
        end else if (!stall) begin
          ifid_bubble = 1'b1;
        end
        if (imem.valid) begin
          fetch_addr_d = pc_d;
          state_d      = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM, PC, fetch address and hold buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      hold_q       <= NOP_WORD;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      hold_q       <= hold_d;
    end
  end

  assign imem.req  = (state_q == StReq) || (state_q == StDrain);
  assign imem.addr = fetch_addr_q;

  if_id_reg #(
    .NOP_WORD(NOP_WORD)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (ifid_load),
    .bubble     (ifid_bubble),
    .instr_d    (ifid_instr),
    .next_addr_d(pc_plus4),
    .valid_d    (1'b1),
    .instr      (Instruction),
    .next_addr  (Next_Address),
    .valid      (if_valid)
  );

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 32-bit 5-stage pipeline. It is the producer end of the IF→ID interface and the consumer of the ID stage's redirect and stall outputs (PCSrc, Branch_Address, flush, PCWrite, freeze).
- Owns the PC, a single-outstanding request/valid instruction-memory port, and the IF/ID pipeline register that drives Instruction and Next_Address into the ID stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word injected as a bubble.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- PCWrite  in  1  1 = PC may advance; 0 = stall from the hazard detector.
- freeze  in  1  1 = hold IF/ID contents (ID stalled).
- PCSrc  in  1  1 = branch taken; redirect to Branch_Address.
- flush  in  1  1 = squash the IF/ID contents.
- Branch_Address  in  32  redirect target.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  request address; stable while the request is outstanding.
- imem_rdata  in  32  returned instruction; valid only when imem_valid=1.
- imem_valid  in  1  one-cycle response strobe; at least 1 cycle after the request is first raised.
- Instruction  out  32  IF/ID instruction.
- Next_Address  out  32  IF/ID PC+4 of that instruction.
- if_valid  out  1  1 = Instruction is a real fetched word.

Behaviour:
- Definitions:
  - stall = freeze | ~PCWrite.
  - redirect = PCSrc | flush; the target is Branch_Address when PCSrc=1, otherwise the PC is unchanged.
  - Priority: rst > redirect > stall > normal.
- Reset (rst=0, asynchronous):
  - PC=RESET_PC, fetch_addr=RESET_PC, state=IDLE.
  - Instruction=NOP_WORD, Next_Address=0, if_valid=0, imem_req=0, hold buffer empty.
- Memory protocol:
  - imem_req=1 only in REQ and DRAIN. imem_addr=fetch_addr.
  - At most one request is outstanding. A request completes on the cycle imem_valid=1.
  - If imem_req is still 1 the following cycle, that is a new request at the then-current fetch_addr.
  - imem_valid while imem_req=0 is ignored.
- State machine (IDLE, REQ, HOLD, DRAIN):
  - IDLE: one cycle after reset release, with req=0, then go to REQ. fetch_addr=PC.
  - REQ, imem_valid=1 and no redirect and not stall:
    - IF/ID ← {imem_rdata, PC+4, valid=1}.
    - PC ← PC+4 and fetch_addr ← PC+4.
    - Stay in REQ. Back-to-back fetch gives a 1-instruction/cycle peak.
  - REQ, imem_valid=1 and stall:
    - hold buffer ← imem_rdata. IF/ID unchanged; PC unchanged.
    - Go to HOLD.
  - REQ, imem_valid=1 and redirect:
    - Discard imem_rdata. PC and fetch_addr ← target.
    - IF/ID ← bubble (NOP_WORD, Next_Address 0, valid=0). Stay in REQ.
  - REQ, imem_valid=0 and redirect:
    - PC ← target. IF/ID ← bubble. Go to DRAIN; fetch_addr is kept.
  - REQ, imem_valid=0 and no redirect:
    - If stall, IF/ID holds; otherwise IF/ID ← bubble.
  - HOLD (req=0):
    - When not stall: IF/ID ← {buffer, PC+4, 1}, PC and fetch_addr ← PC+4, go to REQ.
    - Redirect: drop the buffer, PC and fetch_addr ← target, IF/ID ← bubble, go to REQ.
  - DRAIN (req=1 at the old fetch_addr):
    - On imem_valid: discard the data, fetch_addr ← PC, go to REQ.
    - Another redirect while in DRAIN: PC ← latest target; IF/ID ← bubble.
- Output updates:
  - freeze=1 with no redirect: IF/ID holds all three fields in every state.
  - flush=1 always bubbles IF/ID in that cycle, whatever the state or stall.
- Arithmetic: PC+4 is modulo 2^32. 32'hFFFF_FFFC wraps to 0 with no flag. Bits [1:0] of the PC are carried through as given.
- Reset mid-request: the state returns to IDLE. A late imem_valid that arrives after reset release is ignored unless it comes in REQ; the memory model must also be reset.

Decomposition:
- Shared package (pipeline_pkg):
  - State encoding (IDLE, REQ, HOLD, DRAIN).
  - NOP_WORD and the RESET_PC default.
  - The IF/ID field widths.
- One sub-module: if_id_reg. It is the IF/ID register with async active-low reset, and inputs load, bubble and {instr, next_addr, valid}. if_stage holds the FSM, PC and hold buffer.

Test Plan:
- Reset release, then a memory with 1-cycle latency returning 0x2001_0005 at address 0 → imem_req rises 1 cycle after IDLE with imem_addr=0. The next cycle gives Instruction=0x2001_0005, Next_Address=4, if_valid=1, and imem_addr=4.
- freeze=1, PCWrite=0 for 3 cycles while the response for address 8 arrives → IF/ID holds the previous word, state is HOLD, imem_req=0. After release, Instruction equals the word at 8, Next_Address=0xC, and the fetch for 0xC is issued.
- PCSrc=1, flush=1, Branch_Address=0x40 while a 3-cycle-latency request to 0x10 is outstanding → the bubble is loaded (if_valid=0) and imem_addr stays 0x10 until valid. That data is discarded, the next imem_addr is 0x40, and the first valid instruction has Next_Address=0x44.
- Redirect in the same cycle as imem_valid → the data is discarded, there is no DRAIN, and imem_addr=target the next cycle.
- PC=0xFFFF_FFFC fetch accepted → Next_Address=0 and the next imem_addr=0.
- rst asserted mid-request, asynchronously, between clock edges → the outputs go to their reset values immediately. After release, the first request is at RESET_PC.
